// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory port arbiter.
// Byte lane 0 of a word is the most significant byte.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE,
    I_ACC,
    D_ACC
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W = 4;

  typedef logic [0:BYTES_PER_WORD-1][7:0] word_t;
endpackage

// File: rtl/mem_lat_counter.sv
// Memory latency down-counter: loads MEM_LATENCY-1,
// decrements to zero and flags when it gets there.
module mem_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic load,
  input  logic dec,
  output logic zero
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(MEM_LATENCY - 1);
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-cache refill (read)
// and D-cache MEM stage (read/write), alternating on contention.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  word_t             d_wdata,
  output logic              d_ack,
  output word_t             rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output word_t             mem_data_in,
  output logic              mem_write_en,
  input  word_t             mem_data_out,
  output logic              busy
);
  arb_state_t        state_q, state_d;
  grant_t            last_q, last_d;
  logic [ADDR_W-1:2] addr_q, addr_d;
  logic              we_q, we_d;
  word_t             wdata_q, wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  word_t             rdata_q, rdata_d;
  logic              load, dec, cnt_zero;
  logic              i_go, d_go;
  logic              unused_lsb;

  mem_lat_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_cnt (
    .clk  (clk),
    .rst_b(rst_b),
    .load (load),
    .dec  (dec),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    rdata_d = rdata_q;
    load    = 1'b0;
    dec     = 1'b0;
    // A requester is blind in its own ack cycle.
    i_go    = i_req && !i_ack_q;
    d_go    = d_req && !d_ack_q;
    unique case (state_q)
      IDLE: begin
        if (d_go && (!i_go || last_q == GRANT_I)) begin
          state_d = D_ACC;
          last_d  = GRANT_D;
          addr_d  = d_addr[ADDR_W-1:2];
          we_d    = d_we;
          wdata_d = d_wdata;
          load    = 1'b1;
        end else if (i_go) begin
          state_d = I_ACC;
          last_d  = GRANT_I;
          addr_d  = i_addr[ADDR_W-1:2];
          we_d    = 1'b0;
          load    = 1'b1;
        end
      end
      I_ACC, D_ACC: begin
        if (cnt_zero) begin
          state_d = IDLE;
          i_ack_d = (state_q == I_ACC);
          d_ack_d = (state_q == D_ACC);
          if (!we_q) rdata_d = mem_data_out;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      last_q  <= GRANT_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign unused_lsb   = ^{i_addr[1:0], d_addr[1:0]};
  assign i_ack        = i_ack_q;
  assign d_ack        = d_ack_q;
  assign rdata        = rdata_q;
  assign mem_addr     = {addr_q, 2'b00};
  assign mem_data_in  = (state_q == D_ACC) ? wdata_q : '0;
  assign mem_write_en = (state_q == D_ACC) && we_q && cnt_zero;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed traffic on both requesters, scored against
// a transaction-level model of the shared memory port.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int LAT = 4;
  localparam int AW  = 32;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic          i_req, i_ack, d_req, d_we, d_ack, mem_write_en, busy;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  word_t         d_wdata, rdata, mem_data_in, mem_data_out;

  logic          i_req1, i_ack1, d_req1, d_we1, d_ack1, mem_write_en1, busy1;
  logic [AW-1:0] i_addr1, d_addr1, mem_addr1;
  word_t         d_wdata1, rdata1, mem_data_in1, mem_data_out1;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .rdata(rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(AW)) u_dut1 (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1),
    .d_wdata(d_wdata1), .d_ack(d_ack1), .rdata(rdata1),
    .mem_addr(mem_addr1), .mem_data_in(mem_data_in1),
    .mem_write_en(mem_write_en1), .mem_data_out(mem_data_out1),
    .busy(busy1)
  );

  function automatic word_t init_word(input int k);
    logic [7:0] b;
    b = k[7:0];
    if (k == 4) return 32'h11223344;
    return {b ^ 8'h5a, ~b, b + 8'd17, 8'hc3};
  endfunction

  // Memory behind the port under test; the reference keeps its own copy.
  word_t mem [256];
  word_t ref_mem [256];
  bit    mem_init = 1'b1;
  assign mem_data_out  = mem[mem_addr[9:2]];
  assign mem_data_out1 = ~mem_addr1;
  always @(posedge clk)
    if (mem_init) for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
    else if (mem_write_en) mem[mem_addr[9:2]] <= mem_data_in;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit            is_d;
    int            cyc;
    logic [AW-1:0] addr;
    word_t         rdata;
  } exp_t;
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    word_t         data;
  } wr_t;
  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    word_t         data;
  } req_t;

  exp_t ack_q[$], ack1_q[$];
  wr_t  wr_q[$], wr1_q[$];
  req_t dir_i[$], dir_d[$];
  exp_t me, me1;
  wr_t  mw, mw1;
  bit   mon_en = 1'b0;
  bit   mon1_en = 1'b0;
  int   b_lo = 0;
  int   b_hi = 0;

  always @(negedge clk) if (mon_en) begin
    if (i_ack || d_ack) begin
      if (ack_q.size() == 0) chk("spurious_ack", {d_ack, i_ack}, 2'b00);
      else begin
        me = ack_q.pop_front();
        chk("ack_side", {d_ack, i_ack}, me.is_d ? 2'b10 : 2'b01);
        chk("ack_cycle", cyc, me.cyc);
        chk("ack_rdata", rdata, me.rdata);
        chk("ack_addr", mem_addr, me.addr);
      end
    end else if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
      chk("missing_ack", {d_ack, i_ack}, ack_q[0].is_d ? 2'b10 : 2'b01);
      void'(ack_q.pop_front());
    end
    if (mem_write_en) begin
      if (wr_q.size() == 0) chk("spurious_write", mem_write_en, 1'b0);
      else begin
        mw = wr_q.pop_front();
        chk("write_cycle", cyc, mw.cyc);
        chk("write_addr", mem_addr, mw.addr);
        chk("write_data", mem_data_in, mw.data);
      end
    end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
      chk("missing_write", mem_write_en, 1'b1);
      void'(wr_q.pop_front());
    end
    chk("busy", busy, (cyc >= b_lo && cyc < b_hi));
  end

  always @(negedge clk) if (mon1_en) begin
    if (i_ack1 || d_ack1) begin
      if (ack1_q.size() == 0) chk("l1_spurious_ack", {d_ack1, i_ack1}, 2'b00);
      else begin
        me1 = ack1_q.pop_front();
        chk("l1_ack_side", {d_ack1, i_ack1}, me1.is_d ? 2'b10 : 2'b01);
        chk("l1_ack_cycle", cyc, me1.cyc);
        chk("l1_rdata", rdata1, me1.rdata);
      end
    end else if (ack1_q.size() > 0 && ack1_q[0].cyc <= cyc) begin
      chk("l1_missing_ack", {d_ack1, i_ack1}, ack1_q[0].is_d ? 2'b10 : 2'b01);
      void'(ack1_q.pop_front());
    end
    if (mem_write_en1) begin
      if (wr1_q.size() == 0) chk("l1_spurious_write", mem_write_en1, 1'b0);
      else begin
        mw1 = wr1_q.pop_front();
        chk("l1_write_cycle", cyc, mw1.cyc);
        chk("l1_write_addr", mem_addr1, mw1.addr);
        chk("l1_write_data", mem_data_in1, mw1.data);
      end
    end else if (wr1_q.size() > 0 && wr1_q[0].cyc <= cyc) begin
      chk("l1_missing_write", mem_write_en1, 1'b1);
      void'(wr1_q.pop_front());
    end
  end

  // Transaction-level model of the port.
  bit            pend [2];
  bit            granted [2];
  bit            relaunch [2];
  int            ack_at [2];
  logic [AW-1:0] p_addr [2];
  bit            p_we [2];
  word_t         p_data [2];
  bit            last_d;
  int            free_e;
  word_t         exp_rd;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; granted[k] = 0; relaunch[k] = 0;
    end
    last_d = 0; free_e = 0; exp_rd = '0; b_lo = 0; b_hi = 0;
  endtask

  task automatic drive(input bit s, input bit rq, input logic [AW-1:0] a,
                       input bit we, input word_t dt);
    if (!s) begin
      i_req = rq; i_addr = a;
    end else begin
      d_req = rq; d_addr = a; d_we = we; d_wdata = dt;
    end
  endtask

  task automatic traffic(input int ncyc, input bit rnd);
    int n = 0;
    int a_e, idx;
    bit s, launch, stop;
    req_t r;
    logic [AW-1:0] wa;
    forever begin
      @(posedge clk); #1;
      stop = (n >= ncyc);
      for (int k = 0; k < 2; k++) begin
        if (granted[k] && ack_at[k] == cyc) begin
          granted[k] = 0;
          relaunch[k] = rnd && !stop && ($urandom_range(0, 1) == 1);
          drive(k[0], relaunch[k], $urandom, 1'b1, word_t'($urandom));
        end else if (granted[k]) begin
          drive(k[0], 1'b1, $urandom, $urandom_range(0, 1) == 1,
                word_t'($urandom));
        end else if (!pend[k]) begin
          launch = 0;
          if (!rnd && k == 0 && dir_i.size() > 0) begin
            r = dir_i.pop_front(); launch = 1;
          end else if (!rnd && k == 1 && dir_d.size() > 0) begin
            r = dir_d.pop_front(); launch = 1;
          end else if (rnd && !stop &&
                       (relaunch[k] || $urandom_range(0, 2) == 0)) begin
            r = '{$urandom_range(0, 1) == 1, $urandom, word_t'($urandom)};
            launch = 1;
          end
          relaunch[k] = 0;
          if (launch) begin
            pend[k] = 1;
            p_addr[k] = r.addr;
            p_we[k] = (k == 1) && r.we;
            p_data[k] = r.data;
            drive(k[0], 1'b1, r.addr, r.we, r.data);
          end else begin
            drive(k[0], 1'b0, $urandom, 1'b1, word_t'($urandom));
          end
        end
      end
      if (n >= ncyc && !pend[0] && !pend[1] && !granted[0] && !granted[1]
          && dir_i.size() == 0 && dir_d.size() == 0) break;
      if (n > ncyc + 500) begin
        chk("traffic_stall", {pend[1], pend[0]}, 2'b00);
        break;
      end
      a_e = cyc + 1;
      if (a_e >= free_e && (pend[0] || pend[1])) begin
        // D wins a tie unless it had the previous grant.
        s = pend[1] && (!pend[0] || !last_d);
        pend[s] = 0; granted[s] = 1; last_d = s;
        ack_at[s] = a_e + LAT;
        free_e = a_e + LAT + 1;
        wa = {p_addr[s][AW-1:2], 2'b00};
        idx = int'(p_addr[s][9:2]);
        if (p_we[s]) begin
          ref_mem[idx] = p_data[s];
          wr_q.push_back('{a_e + LAT - 1, wa, p_data[s]});
        end else begin
          exp_rd = ref_mem[idx];
        end
        ack_q.push_back('{s, a_e + LAT, wa, exp_rd});
        b_lo = a_e; b_hi = a_e + LAT;
      end
      n++;
    end
  endtask

  task automatic settle();
    repeat (LAT + 2) @(negedge clk);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("write_queue_drained", wr_q.size(), 0);
  endtask

  // Both sides request continuously; the side just acked is blind
  // for one cycle, so grants alternate D, I, D ... every 2 cycles.
  task automatic lat1_run(input int n);
    int free1 = 0;
    int a;
    bit s, last1;
    word_t rd1;
    logic [AW-1:0] wa;
    last1 = 0; rd1 = '0;
    mon1_en = 1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      i_req1 = 1'b1; d_req1 = 1'b1;
      i_addr1 = $urandom; d_addr1 = $urandom;
      d_we1 = $urandom_range(0, 1) == 1; d_wdata1 = word_t'($urandom);
      a = cyc + 1;
      if (a >= free1) begin
        s = !last1;
        wa = s ? {d_addr1[AW-1:2], 2'b00} : {i_addr1[AW-1:2], 2'b00};
        if (s && d_we1) wr1_q.push_back('{a, wa, d_wdata1});
        else rd1 = ~wa;
        ack1_q.push_back('{s, a + 1, wa, rd1});
        last1 = s; free1 = a + 2;
      end
    end
    @(posedge clk); #1;
    i_req1 = 1'b0; d_req1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("l1_ack_queue_drained", ack1_q.size(), 0);
    chk("l1_write_queue_drained", wr1_q.size(), 0);
    mon1_en = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    model_reset();
    repeat (4) begin
      @(posedge clk); #1;
      i_req = $urandom; i_addr = $urandom; d_req = $urandom;
      d_we = $urandom; d_addr = $urandom; d_wdata = word_t'($urandom);
      i_req1 = $urandom; i_addr1 = $urandom; d_req1 = $urandom;
      d_we1 = $urandom; d_addr1 = $urandom; d_wdata1 = word_t'($urandom);
      @(negedge clk);
      chk("reset_outputs", {i_ack, d_ack, rdata, mem_addr, mem_data_in,
                            mem_write_en, busy}, '0);
      chk("reset_outputs_l1", {i_ack1, d_ack1, rdata1, mem_addr1,
                               mem_data_in1, mem_write_en1, busy1}, '0);
    end
    mem_init = 0;
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    i_req1 = 0; d_req1 = 0; i_addr1 = '0; d_addr1 = '0;
    d_we1 = 0; d_wdata1 = '0;
    @(negedge clk);
    rst_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_reset", {i_ack, d_ack, busy, mem_write_en, rdata}, '0);
    end

    mon_en = 1;
    dir_i.push_back('{1'b0, 32'h13, '0});
    traffic(0, 0);
    dir_d.push_back('{1'b1, 32'h20, 32'haabbccdd});
    traffic(0, 0);
    dir_i.push_back('{1'b0, 32'h22, '0});
    traffic(0, 0);
    dir_i.push_back('{1'b0, 32'h30, '0});
    dir_d.push_back('{1'b0, 32'h10, '0});
    dir_d.push_back('{1'b1, 32'h34, 32'h01020304});
    traffic(0, 0);
    traffic(300, 1);
    settle();

    // Reset lands two counts before the write strobe.
    mon_en = 0;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'h44, 1'b1, 32'hdeadbeef);
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_before_reset", busy, 1'b1);
    rst_b = 1'b0;
    #1;
    chk("reset_mid_write", {busy, mem_write_en, d_ack}, 3'b000);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    repeat (LAT + 2) begin
      @(negedge clk);
      chk("held_in_reset", {d_ack, mem_write_en, busy}, 3'b000);
    end
    chk("no_partial_write", mem[17], ref_mem[17]);
    rst_b = 1'b1;
    model_reset();
    mon_en = 1;
    dir_d.push_back('{1'b0, 32'h44, '0});
    traffic(0, 0);
    traffic(200, 1);
    settle();
    mon_en = 0;

    lat1_run(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
